muldiv_seq: RTL and testbench

Iterative sequencer for the RV32-M operations (funct3 000-111 with funct7 0000001). It accepts one request at a time through a start/ready handshake and runs a shared 32-step shift-add multiplier / restoring divider over operand magnitudes. It applies RISC-V sign fix-up and special cases, then returns a result with a one-cycle done pulse. It sits beside the single-cycle integer ALU, and the core stalls on busy while an M-op is in flight.

---
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32-M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// A shared 32-step engine runs over operand magnitudes. It works as a shift-add
// multiplier or as a restoring divider. Sign fix-up is applied afterwards.
// Divide-by-zero and signed overflow bypass the engine and finish in one cycle.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request valid, accepted only while ready
//   funct3          M-op select
//   a, b            rs1 / rs2 operands, sampled at acceptance only
//   kill            flush, abandons the in-flight op and suppresses done
//   ready           high in IDLE
//   busy            high in CALC, FIXUP and DONE
//   done            one-cycle pulse, res valid in that cycle
//   res             result, held until the next done
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [XLEN-1:0]  r_a;      // |a|: multiplicand
    logic [XLEN-1:0]  r_b;      // |b|: divisor
    logic [XLEN-1:0]  r_hi;     // product high / partial remainder
    logic [XLEN-1:0]  r_lo;     // product low (multiplier) / quotient (dividend)
    logic [XLEN-1:0]  r_pend;   // result waiting for the DONE cycle
    logic [XLEN-1:0]  r_res;    // last delivered result

    // ---------------- acceptance decode ----------------
    logic            w_is_div, w_sa, w_sb, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;
    logic            w_div0, w_ovf;

    always_comb begin
        w_is_div = funct3[2];
        // Signed a: MULH, MULHSU, DIV, REM. Signed b: MULH, DIV, REM.
        w_sa     = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sb     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_a_neg  = w_sa && a[XLEN-1];
        w_b_neg  = w_sb && b[XLEN-1];
        w_a_mag  = w_a_neg ? -a : a;
        w_b_mag  = w_b_neg ? -b : b;
        w_div0   = w_is_div && (b == '0);
        w_ovf    = w_is_div && !funct3[0] && (a == MIN_NEG) && (b == '1);
        // funct3[1] selects the remainder among the div ops.
        if (w_div0)
            w_fast_res = funct3[1] ? a : '1;
        else
            w_fast_res = funct3[1] ? '0 : MIN_NEG;
    end

    // ---------------- iteration step ----------------
    logic [XLEN:0]   w_msum;    // 33-bit so the add carry shifts into hi
    logic [XLEN:0]   w_rshift;  // remainder after the left shift, may need 33 bits
    logic            w_ge;
    logic [XLEN-1:0] w_rdiff;

    always_comb begin
        w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_rshift = {r_hi, r_lo[XLEN-1]};
        w_ge     = (w_rshift >= {1'b0, r_b});
        // Only used when w_ge, so the difference is below |b| and fits XLEN bits.
        w_rdiff  = w_rshift[XLEN-1:0] - r_b;
    end

    // ---------------- sign fix-up and select ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_f;
    logic [XLEN-1:0]   w_quo_f, w_rem_f, w_fix_res;

    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_f = r_neg_res ? -w_prod : w_prod;
        w_quo_f  = r_neg_res ? -r_lo : r_lo;
        w_rem_f  = r_neg_rem ? -r_hi : r_hi;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_f[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_f[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo_f;
            default:                w_fix_res = w_rem_f;
        endcase
    end

    // ---------------- control FSM and datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend    <= '0;
            r_res     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        r_op      <= funct3;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_is_div && w_a_neg;
                        r_a       <= w_a_mag;
                        r_b       <= w_b_mag;
                        r_hi      <= '0;
                        r_lo      <= w_is_div ? w_a_mag : w_b_mag;
                        if (w_div0 || w_ovf) begin
                            r_pend  <= w_fast_res;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_rdiff : w_rshift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_hi <= w_msum[XLEN:1];
                            r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE)
                            r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_pend  <= w_fix_res;
                        r_state <= S_DONE;
                    end
                end
                default: begin  // S_DONE
                    if (!kill)
                        r_res <= r_pend;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // done and res are gated by kill during the DONE cycle. A flush in that
    // cycle must hide the result, so the gating cannot be registered.
    always_comb begin
        ready = (r_state == S_IDLE);
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE) && !kill;
        res   = done ? r_pend : r_res;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, busy, done;
    logic [31:0] res;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .a(a), .b(b), .kill(kill),
        .ready(ready), .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then scramble the operands, then wait for done and check latency and result.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] exp, input int lat);
        int   n;
        logic seen;
        check({tag, " ready@start"}, 32'(ready), 32'd1);
        start = 1'b1; funct3 = f; a = aa; b = bb;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
        n = 1;
        seen = done;
        while (!seen && n < 60) begin
            tick();
            n++;
            seen = done;
        end
        check({tag, " done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, n, lat);
        check({tag, " res"}, res, exp);
        tick();
        check({tag, " ready@end"}, 32'(ready), 32'd1);
        check({tag, " res held"}, res, exp);
    endtask

    initial begin
        int dones;
        int first;

        // Reset state.
        tick();
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst res", res, 32'h0);
        rst_n = 1'b1;
        tick();

        // Multiplies.
        run_op("MUL 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("MULH 7*-3",    3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("MULHU 7*-3",   3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 34);
        run_op("MULHSU -1*ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("MUL min*min",  3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 34);

        // Divides, normal path.
        run_op("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("REM -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("DIVU 100/7",   3'b101, 32'd100,      32'd7,        32'd14,       34);
        run_op("REMU 100/7",   3'b111, 32'd100,      32'd7,        32'd2,        34);
        run_op("DIV 7/-2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        run_op("REM 7/-2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
        run_op("REM -7/-2",    3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34);
        run_op("DIV -7/-2",    3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34);

        // Fast path.
        run_op("DIV 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("DIVU 5/0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REM 5/0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("REMU 5/0",     3'b111, 32'd5,        32'd0,        32'd5,        1);
        run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        // Same operands unsigned are not an overflow case.
        run_op("DIVU min/ff",  3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("REMU min/ff",  3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

        // kill beats start in IDLE.
        start = 1'b1; kill = 1'b1; funct3 = 3'b101; a = 32'd5; b = 32'd0;
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill+start ready", 32'(ready), 32'd1);
        check("kill+start done", 32'(done), 32'd0);

        // kill at cycle 10 of a DIVU.
        dones = 0;
        start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            if (done) dones++;
            tick();
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill ready", 32'(ready), 32'd1);
        check("kill busy", 32'(busy), 32'd0);
        check("kill no done", 32'(dones + int'(done)), 32'd0);
        check("kill res kept", res, 32'h80000000);
        run_op("DIVU after kill", 3'b101, 32'd100, 32'd7, 32'd14, 34);

        // kill during the DONE cycle.
        start = 1'b1; funct3 = 3'b100; a = 32'd5; b = 32'd0;
        tick();
        start = 1'b0;
        check("done-cycle done", 32'(done), 32'd1);
        kill = 1'b1;
        #1;
        check("done-cycle killed", 32'(done), 32'd0);
        check("done-cycle res", res, 32'd14);
        tick();
        kill = 1'b0;
        check("done-cycle ready", 32'(ready), 32'd1);
        check("done-cycle res kept", res, 32'd14);

        // start while busy is ignored. Exactly one done is expected.
        dones = 0; first = 0;
        start = 1'b1; funct3 = 3'b000; a = 32'd7; b = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        for (int n = 1; n < 45; n++) begin
            if (done) begin
                dones++;
                if (first == 0) first = n;
                check("busy-ign res", res, 32'hFFFFFFEB);
            end
            if (n == 5) begin start = 1'b1; funct3 = 3'b101; a = 32'd5; b = 32'd0; end
            if (n == 6) start = 1'b0;
            tick();
        end
        check("busy-ign dones", dones, 32'd1);
        check("busy-ign latency", first, 32'd34);

        // Asynchronous reset mid-MUL.
        start = 1'b1; funct3 = 3'b000; a = 32'd7; b = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        for (int n = 1; n < 20; n++) tick();
        rst_n = 1'b0;
        #2;
        check("async rst ready", 32'(ready), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst res", res, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("MULHU after rst", 3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
